// File: rtl/oled_fb_scanout.sv
// Frame scan-out: one SPI mode-0 transaction per start pulse; column/page window header followed by every framebuffer byte, MSB first.
// Optional macro OLED_INIT_EN prepends a 25-byte panel init block to the first frame after reset.
module oled_fb_scanout #(
  parameter int XSIZE      = 128,
  parameter int YSIZE      = 64,
  parameter int ADDR_DEPTH = XSIZE * YSIZE / 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(ADDR_DEPTH)-1:0] fb_rd_addr,
  output logic                          fb_cs,
  input  logic [7:0]                    fb_data,
  output logic                          oled_sclk,
  output logic                          oled_mosi,
  output logic                          oled_dc,
  output logic                          oled_cs_n
);

  localparam int AW = $clog2(ADDR_DEPTH);
  localparam int CW = $clog2(ADDR_DEPTH + 32);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Stream index map: 0..24 init block, 25..30 header, 31.. framebuffer bytes.
  localparam logic [CW-1:0] HDR_IDX  = CW'(25);
  localparam logic [CW-1:0] DATA_IDX = CW'(31);
  localparam logic [CW-1:0] LAST_IDX = CW'(ADDR_DEPTH + 30);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, FINISH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    sr_q, sr_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          dc_q, dc_d;
  logic          is_data;
  logic [7:0]    load_byte;
  logic [CW-1:0] first_idx;

  function automatic logic [7:0] cmd_rom(input logic [4:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
`ifdef OLED_INIT_EN
      5'd0:  b = 8'hAE;
      5'd1:  b = 8'hD5;
      5'd2:  b = 8'h80;
      5'd3:  b = 8'hA8;
      5'd4:  b = 8'h3F;
      5'd5:  b = 8'hD3;
      5'd6:  b = 8'h00;
      5'd7:  b = 8'h40;
      5'd8:  b = 8'h8D;
      5'd9:  b = 8'h14;
      5'd10: b = 8'h20;
      5'd11: b = 8'h00;
      5'd12: b = 8'hA1;
      5'd13: b = 8'hC8;
      5'd14: b = 8'hDA;
      5'd15: b = 8'h12;
      5'd16: b = 8'h81;
      5'd17: b = 8'hCF;
      5'd18: b = 8'hD9;
      5'd19: b = 8'hF1;
      5'd20: b = 8'hDB;
      5'd21: b = 8'h40;
      5'd22: b = 8'hA4;
      5'd23: b = 8'hA6;
      5'd24: b = 8'hAF;
`endif
      5'd25: b = 8'h21;
      5'd26: b = 8'h00;
      5'd27: b = 8'(XSIZE - 1);
      5'd28: b = 8'h22;
      5'd29: b = 8'h00;
      5'd30: b = 8'(YSIZE / 8 - 1);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef OLED_INIT_EN
  logic init_done_q, init_done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) init_done_q <= 1'b0;
    else       init_done_q <= init_done_d;
  end

  assign init_done_d = init_done_q | (state_q == FINISH);
  assign first_idx   = init_done_q ? HDR_IDX : '0;
`else
  assign first_idx   = HDR_IDX;
`endif

  assign is_data   = (cnt_q >= DATA_IDX);
  assign load_byte = is_data ? fb_data : cmd_rom(cnt_q[4:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          cnt_d   = first_idx;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        // MSB goes out with the first low-phase cycle of SHIFT.
        state_d = SHIFT;
        sr_d    = load_byte[6:0];
        mosi_d  = load_byte[7];
        dc_d    = is_data;
        div_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd7) begin
              if (cnt_q == LAST_IDX) begin
                state_d = FINISH;
              end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = FETCH;
              end
            end else begin
              bit_d  = bit_q + 1'b1;
              mosi_d = sr_q[6];
              sr_d   = {sr_q[5:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign oled_cs_n  = !((state_q == FETCH) || (state_q == LOAD) || (state_q == SHIFT));
  assign fb_cs      = is_data && ((state_q == FETCH) || (state_q == LOAD));
  assign fb_rd_addr = (is_data && busy) ? AW'(cnt_q - DATA_IDX) : '0;
  assign oled_sclk  = sclk_q;
  assign oled_mosi  = mosi_q;
  assign oled_dc    = dc_q;

endmodule

// File: doc/oled_fb_scanout.md
# oled_fb_scanout

Frame scan-out engine between the framebuffer and the SSD1306-class SPI OLED panel. On a `start` pulse it opens one SPI transaction, sends a column/page window header, then streams every framebuffer byte in address order to the panel. It drives the framebuffer read port (`rd_addr`, `cs`) directly and serialises each byte MSB-first in SPI mode 0.

## Interface
- `XSIZE`, 128: panel width in pixels.
- `YSIZE`, 64: panel height in pixels; must be a multiple of 8.
- `ADDR_DEPTH`, XSIZE*YSIZE/8: framebuffer depth in bytes.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; minimum 1.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request one frame refresh; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle after `done`.
- `done` out 1: one-cycle pulse at the end of the frame.
- `fb_rd_addr` out $clog2(ADDR_DEPTH): framebuffer read address.
- `fb_cs` out 1: framebuffer chip select.
- `fb_data` in 8: framebuffer read data; valid one cycle after `fb_rd_addr` is presented with `fb_cs`=1.
- `oled_sclk` out 1: SPI clock; idles low.
- `oled_mosi` out 1: SPI data, MSB first.
- `oled_dc` out 1: 0 = command byte, 1 = display data byte.
- `oled_cs_n` out 1: panel select, active low.

## Operation
- States: IDLE, FETCH, LOAD, SHIFT, FINISH.
- Byte stream per frame:
  - Optional init block (see Configuration).
  - Header: 0x21, 0x00, XSIZE-1, 0x22, 0x00, YSIZE/8-1. These are 6 command bytes, `oled_dc`=0.
  - ADDR_DEPTH data bytes from addresses 0..ADDR_DEPTH-1, `oled_dc`=1.
- IDLE:
  - If `start`=1 at a clock edge, go to FETCH.
  - `oled_cs_n` goes to 0 and `busy` goes to 1 at that edge.
- FETCH, 1 cycle:
  - For a data byte: `fb_rd_addr`=byte index and `fb_cs`=1.
  - For a command byte: `fb_cs`=0.
- LOAD, 1 cycle:
  - `fb_cs` stays 1 for data bytes.
  - At the end of LOAD the shift register captures `fb_data` (data byte) or the command ROM byte (command byte).
  - `oled_dc` is updated.
- SHIFT, 16*CLK_DIV cycles:
  - Each bit has CLK_DIV cycles with `oled_sclk`=0, then CLK_DIV cycles with `oled_sclk`=1.
  - `oled_mosi` changes only on the low phase, at its first cycle; the panel samples on the SCLK rising edge.
  - After bit 0, go to FETCH for the next byte, or to FINISH after the last byte.
- FINISH, 1 cycle: `oled_cs_n`=1, `oled_sclk`=0, `done`=1. Then go to IDLE with `busy`=0.
- `fb_cs`=0 everywhere outside FETCH/LOAD of data bytes. The framebuffer tristates `out` when deselected, so `fb_data` is ignored there.
- A byte counter wide enough for ADDR_DEPTH+31 selects the command ROM index or the fb address. At the last index it terminates the frame; it does not wrap.
- `start` while busy is ignored and not queued.

## Timing
- Reset values (asynchronous, immediate, including mid-frame):
  - `busy`=0, `done`=0, `fb_cs`=0, `fb_rd_addr`=0.
  - `oled_sclk`=0, `oled_mosi`=0, `oled_dc`=0, `oled_cs_n`=1.
  - State is IDLE; any partial frame is abandoned.
- Byte period: 16*CLK_DIV+2 cycles.
- Frame length: `busy` is high for N*(16*CLK_DIV+2)+1 cycles, where N is the total byte count. Default N=1030 gives 67981 cycles.
- `oled_cs_n` stays low continuously from the first FETCH to FINISH, with no deassertion between bytes.
- `start` held high continuously causes back-to-back frames, with exactly one IDLE cycle between `done` and the next `busy`.
- `oled_dc` is stable for the entire SHIFT of its byte.

## Configuration
- `OLED_INIT_EN` defined:
  - The first frame after each reset prepends a 25-byte command block before the header: 0xAE, 0xD5, 0x80, 0xA8, 0x3F, 0xD3, 0x00, 0x40, 0x8D, 0x14, 0x20, 0x00, 0xA1, 0xC8, 0xDA, 0x12, 0x81, 0xCF, 0xD9, 0xF1, 0xDB, 0x40, 0xA4, 0xA6, 0xAF.
  - All 25 bytes are sent with `oled_dc`=0, inside the same `oled_cs_n` window.
  - A sticky `init_done` flag, cleared by `reset`, suppresses the block on later frames.
  - The first frame has N=1055 bytes.
- `OLED_INIT_EN` undefined:
  - No init ROM or flag is built, and every frame has N=ADDR_DEPTH+6.
  - The panel must already be in horizontal addressing mode.

## Test plan
- Basic frame, macro off: fb preloaded with byte i = i[7:0], CLK_DIV=1, one `start` pulse.
  - SPI monitor decodes commands 0x21, 0x00, 0x7F, 0x22, 0x00, 0x07, then data 0x00..0xFF repeating for 1024 bytes.
  - `done` asserts 1030*18+1 cycles after `busy` rises.
- Mode-0 timing, CLK_DIV=4:
  - Every `oled_mosi` transition occurs while `oled_sclk`=0.
  - Each SCLK high and low phase is exactly 4 cycles.
  - `oled_cs_n` never rises mid-frame.
- Framebuffer port: check `fb_cs`=1 only during data FETCH/LOAD, and `fb_rd_addr` increments 0..1023 exactly once per byte.
- Reset mid-frame: assert `reset` during byte 300.
  - All outputs take their reset values in the same cycle.
  - The next `start` restarts the header from 0x21.
- `start` held high for two frames: second `busy` rises exactly 1 cycle after `done`; a `start` pulse mid-frame has no effect.
- Macro on: the first frame has 25 init bytes with `oled_dc`=0 followed by the header; the second frame begins directly with 0x21; total bytes are 1055 and 1030.
